// File: rtl/cpu_pkg.sv
// Shared definitions for the instruction fetch path.
// Contents: fetch FSM state encoding, the HALT opcode value, the two-byte
// opcode prefix, and a helper that classifies an opcode byte.
package cpu_pkg;

    typedef enum logic [1:0] {
        FETCH_OP  = 2'd0,
        FETCH_IMM = 2'd1,
        HALT      = 2'd2
    } fetch_state_t;

    localparam logic [7:0] HALT_OPCODE     = 8'hFF;
    localparam logic [1:0] TWO_BYTE_PREFIX = 2'b10;

    // 8'hFF has top bits 2'b11, so it can never be mistaken for a two-byte opcode.
    function automatic logic is_two_byte(input logic [7:0] op);
        return op[7:6] == TWO_BYTE_PREFIX;
    endfunction

endpackage

// File: rtl/pc_register.sv
// 8-bit program counter with load / increment / hold.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset (loads RESET_VALUE)
//   load        - load load_value (wins over inc)
//   load_value  - value loaded when load=1
//   inc         - increment by one, modulo 256
//   pc          - current counter value
module pc_register #(
    parameter logic [7:0] RESET_VALUE = 8'h00
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] load_value,
    input  logic       inc,
    output logic [7:0] pc
);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its inputs from before the edge, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_VALUE;
        end else if (load) begin
            pc <= load_value;
        end else if (inc) begin
            pc <= pc + 8'd1;  // wraps 8'hFF -> 8'h00
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: reads one byte per cycle from a combinational
// instruction memory, assembles one- and two-byte instructions and hands them
// to decode over a Valid/Ready handshake. 8'hFF halts fetching until a redirect.
// Ports:
//   Clk, Rst_N        - clock, asynchronous active-low reset
//   Address           - byte address to instruction memory (always the PC)
//   Instruction       - byte returned by memory at Address, same cycle
//   Ready             - decode accepts the output when Valid && Ready
//   Redirect          - branch/jump taken; highest priority event
//   Redirect_Target   - new PC when Redirect=1
//   Valid             - Opcode/Operand/Fetch_PC hold a complete instruction
//   Opcode, Operand   - instruction byte and immediate (8'h00 if one-byte)
//   Fetch_PC          - address of the opcode byte
//   Halted            - HALT instruction fetched and no redirect since
module fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  logic       Clk,
    input  logic       Rst_N,
    output logic [7:0] Address,
    input  logic [7:0] Instruction,
    input  logic       Ready,
    input  logic       Redirect,
    input  logic [7:0] Redirect_Target,
    output logic       Valid,
    output logic [7:0] Opcode,
    output logic [7:0] Operand,
    output logic [7:0] Fetch_PC,
    output logic       Halted
);

    fetch_state_t state;
    logic [7:0]   pc;
    logic [7:0]   pend_opcode;  // opcode byte of a two-byte instruction in flight
    logic [7:0]   pend_pc;
    logic         slot_free;
    logic         pc_inc;

    assign Address   = pc;
    assign slot_free = !Valid || Ready;

    // The PC advances on every byte consumed; a HALT opcode is presented but
    // not stepped over, and a redirect overrides everything.
    // NOTE: always_comb assigns a default first so every path drives pc_inc
    // and no latch is inferred.
    always_comb begin
        pc_inc = 1'b0;
        if (!Redirect) begin
            unique case (state)
                FETCH_OP:  pc_inc = slot_free && (Instruction != HALT_OPCODE);
                FETCH_IMM: pc_inc = 1'b1;
                default:   pc_inc = 1'b0;
            endcase
        end
    end

    pc_register #(
        .RESET_VALUE(RESET_PC)
    ) u_pc (
        .clk        (Clk),
        .rst_n      (Rst_N),
        .load       (Redirect),
        .load_value (Redirect_Target),
        .inc        (pc_inc),
        .pc         (pc)
    );

    always_ff @(posedge Clk or negedge Rst_N) begin
        if (!Rst_N) begin
            state       <= FETCH_OP;
            Valid       <= 1'b0;
            Opcode      <= 8'h00;
            Operand     <= 8'h00;
            Fetch_PC    <= RESET_PC;
            Halted      <= 1'b0;
            pend_opcode <= 8'h00;
            pend_pc     <= RESET_PC;
        end else if (Redirect) begin
            // Any presented instruction is consumed or dropped; a pending
            // opcode is abandoned simply by leaving FETCH_IMM.
            state  <= FETCH_OP;
            Valid  <= 1'b0;
            Halted <= 1'b0;
        end else begin
            unique case (state)
                FETCH_OP: begin
                    if (slot_free) begin
                        if (Instruction == HALT_OPCODE) begin
                            Opcode   <= Instruction;
                            Operand  <= 8'h00;
                            Fetch_PC <= pc;
                            Valid    <= 1'b1;
                            Halted   <= 1'b1;
                            state    <= HALT;
                        end else if (is_two_byte(Instruction)) begin
                            pend_opcode <= Instruction;
                            pend_pc     <= pc;
                            Valid       <= 1'b0;
                            state       <= FETCH_IMM;
                        end else begin
                            Opcode   <= Instruction;
                            Operand  <= 8'h00;
                            Fetch_PC <= pc;
                            Valid    <= 1'b1;
                        end
                    end
                end
                // Valid is always low here, so the slot is free by construction.
                FETCH_IMM: begin
                    Opcode   <= pend_opcode;
                    Operand  <= Instruction;
                    Fetch_PC <= pend_pc;
                    Valid    <= 1'b1;
                    state    <= FETCH_OP;
                end
                HALT: begin
                    if (Valid && Ready) begin
                        Valid <= 1'b0;
                    end
                end
                default: state <= FETCH_OP;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    logic       Clk = 1'b0;
    logic       Rst_N;
    logic [7:0] Address;
    logic [7:0] Instruction;
    logic       Ready;
    logic       Redirect;
    logic [7:0] Redirect_Target;
    logic       Valid;
    logic [7:0] Opcode;
    logic [7:0] Operand;
    logic [7:0] Fetch_PC;
    logic       Halted;

    logic [7:0] mem [256];
    int checks   = 0;
    int failures = 0;

    assign Instruction = mem[Address];

    always #5 Clk = ~Clk;

    fetch_unit #(.RESET_PC(8'h00)) dut (
        .Clk             (Clk),
        .Rst_N           (Rst_N),
        .Address         (Address),
        .Instruction     (Instruction),
        .Ready           (Ready),
        .Redirect        (Redirect),
        .Redirect_Target (Redirect_Target),
        .Valid           (Valid),
        .Opcode          (Opcode),
        .Operand         (Operand),
        .Fetch_PC        (Fetch_PC),
        .Halted          (Halted)
    );

    typedef struct {
        logic       ready;
        logic       redirect;
        logic [7:0] target;
        logic       valid;
        logic [7:0] opcode;
        logic [7:0] operand;
        logic [7:0] fetch_pc;
        logic [7:0] address;
        logic       halted;
    } vec_t;

    vec_t vecs [19];

    function automatic vec_t mk(input logic rdy, input logic rdr, input logic [7:0] tgt,
                                input logic vld, input logic [7:0] op, input logic [7:0] imm,
                                input logic [7:0] fpc, input logic [7:0] addr, input logic hlt);
        vec_t v;
        v.ready = rdy; v.redirect = rdr; v.target = tgt;
        v.valid = vld; v.opcode = op; v.operand = imm; v.fetch_pc = fpc;
        v.address = addr; v.halted = hlt;
        return v;
    endfunction

    task automatic check(input string name, input logic [7:0] actual, input logic [7:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s actual=%02h expected=%02h", name, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic check_beat(input string tag, input logic [7:0] op,
                              input logic [7:0] imm, input logic [7:0] fpc,
                              input logic [7:0] addr);
        check({tag, " valid"},    {7'd0, Valid}, 8'd1);
        check({tag, " opcode"},   Opcode,   op);
        check({tag, " operand"},  Operand,  imm);
        check({tag, " fetch_pc"}, Fetch_PC, fpc);
        check({tag, " address"},  Address,  addr);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h00] = 8'h01; mem[8'h01] = 8'h02;
        mem[8'h02] = 8'h85; mem[8'h03] = 8'h3C;
        mem[8'h04] = 8'h03; mem[8'h05] = 8'hFF;
        mem[8'h10] = 8'h20;
        mem[8'h40] = 8'h85; mem[8'h41] = 8'h77;
        mem[8'h50] = 8'h04;

        // ready rdr tgt   vld op     imm    fpc    addr   hlt
        vecs[0]  = mk(1, 0, 8'h00, 1, 8'h01, 8'h00, 8'h00, 8'h01, 0); // first beat one edge after reset
        vecs[1]  = mk(1, 0, 8'h00, 1, 8'h02, 8'h00, 8'h01, 8'h02, 0);
        vecs[2]  = mk(1, 0, 8'h00, 0, 8'h00, 8'h00, 8'h00, 8'h03, 0); // opcode 85 latched
        vecs[3]  = mk(1, 0, 8'h00, 1, 8'h85, 8'h3C, 8'h02, 8'h04, 0); // two-byte beat
        vecs[4]  = mk(0, 0, 8'h00, 1, 8'h85, 8'h3C, 8'h02, 8'h04, 0); // stall x3
        vecs[5]  = mk(0, 0, 8'h00, 1, 8'h85, 8'h3C, 8'h02, 8'h04, 0);
        vecs[6]  = mk(0, 0, 8'h00, 1, 8'h85, 8'h3C, 8'h02, 8'h04, 0);
        vecs[7]  = mk(1, 0, 8'h00, 1, 8'h03, 8'h00, 8'h04, 8'h05, 0);
        vecs[8]  = mk(1, 0, 8'h00, 1, 8'hFF, 8'h00, 8'h05, 8'h05, 1); // HALT presented
        vecs[9]  = mk(0, 0, 8'h00, 1, 8'hFF, 8'h00, 8'h05, 8'h05, 1);
        vecs[10] = mk(1, 0, 8'h00, 0, 8'h00, 8'h00, 8'h00, 8'h05, 1); // HALT accepted
        vecs[11] = mk(1, 0, 8'h00, 0, 8'h00, 8'h00, 8'h00, 8'h05, 1);
        vecs[12] = mk(1, 1, 8'h10, 0, 8'h00, 8'h00, 8'h00, 8'h10, 0); // redirect out of HALT
        vecs[13] = mk(1, 0, 8'h00, 1, 8'h20, 8'h00, 8'h10, 8'h11, 0);
        vecs[14] = mk(1, 0, 8'h00, 1, 8'h00, 8'h00, 8'h11, 8'h12, 0);
        vecs[15] = mk(1, 1, 8'h40, 0, 8'h00, 8'h00, 8'h00, 8'h40, 0); // redirect with Valid&&Ready
        vecs[16] = mk(1, 0, 8'h00, 0, 8'h00, 8'h00, 8'h00, 8'h41, 0); // in FETCH_IMM
        vecs[17] = mk(1, 1, 8'h50, 0, 8'h00, 8'h00, 8'h00, 8'h50, 0); // redirect drops 85
        vecs[18] = mk(1, 0, 8'h00, 1, 8'h04, 8'h00, 8'h50, 8'h51, 0);

        Rst_N = 1'b0; Ready = 1'b0; Redirect = 1'b0; Redirect_Target = 8'h00;
        #3;
        check("reset address",  Address,  8'h00);
        check("reset valid",    {7'd0, Valid},  8'd0);
        check("reset opcode",   Opcode,   8'h00);
        check("reset operand",  Operand,  8'h00);
        check("reset fetch_pc", Fetch_PC, 8'h00);
        check("reset halted",   {7'd0, Halted}, 8'd0);

        @(negedge Clk);
        Rst_N = 1'b1;

        for (int i = 0; i < 19; i++) begin
            Ready = vecs[i].ready;
            Redirect = vecs[i].redirect;
            Redirect_Target = vecs[i].target;
            step();
            check($sformatf("v%0d valid", i),   {7'd0, Valid},  {7'd0, vecs[i].valid});
            check($sformatf("v%0d address", i), Address,        vecs[i].address);
            check($sformatf("v%0d halted", i),  {7'd0, Halted}, {7'd0, vecs[i].halted});
            if (vecs[i].valid) begin
                check($sformatf("v%0d opcode", i),   Opcode,   vecs[i].opcode);
                check($sformatf("v%0d operand", i),  Operand,  vecs[i].operand);
                check($sformatf("v%0d fetch_pc", i), Fetch_PC, vecs[i].fetch_pc);
            end
        end

        // Two-byte instruction straddling the 8'hFF -> 8'h00 wrap.
        mem[8'hFF] = 8'h90; mem[8'h00] = 8'h11;
        Ready = 1'b1; Redirect = 1'b1; Redirect_Target = 8'hFF;
        step();
        check("wrap redirect address", Address, 8'hFF);
        Redirect = 1'b0;
        step();
        check("wrap imm valid",   {7'd0, Valid}, 8'd0);
        check("wrap imm address", Address, 8'h00);
        step();
        check_beat("wrap beat", 8'h90, 8'h11, 8'hFF, 8'h01);

        // Asynchronous reset while an opcode is pending in FETCH_IMM.
        Redirect = 1'b1; Redirect_Target = 8'h40;
        step();
        Redirect = 1'b0;
        step();
        check("pre-reset address", Address, 8'h41);
        #2;
        Rst_N = 1'b0;
        #1;
        check("async reset address", Address, 8'h00);
        check("async reset valid",   {7'd0, Valid}, 8'd0);
        check("async reset fetch_pc", Fetch_PC, 8'h00);
        @(negedge Clk);
        Rst_N = 1'b1;
        step();
        check_beat("post-reset beat", 8'h11, 8'h00, 8'h00, 8'h01);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 8'h00: PC value loaded on reset.
REQ-002 The block SHALL have port Clk, input, 1: single clock; all state updates on rising edge.
REQ-003 The block SHALL have port Rst_N, input, 1: reset, asynchronous and active-low.
REQ-004 The block SHALL have port Address, output, 8: byte address driven to instruction memory; that memory returns Instruction combinationally in the same cycle.
REQ-005 The block SHALL have port Instruction, input, 8: byte read from memory at Address.
REQ-006 The block SHALL have port Ready, input, 1: decode accepts the current output when Valid && Ready.
REQ-007 The block SHALL have port Redirect, input, 1: branch/jump taken this cycle.
REQ-008 The block SHALL have port Redirect_Target, input, 8: new PC when Redirect=1.
REQ-009 The block SHALL have port Valid, output, 1: Opcode/Operand/Fetch_PC hold a complete instruction.
REQ-010 The block SHALL have ports Opcode, output, 8, and Operand, output, 8: instruction byte, and immediate byte (8'h00 for one-byte instructions).
REQ-011 The block SHALL have ports Fetch_PC, output, 8, and Halted, output, 1: address of the opcode byte; HALT state reached.

Function
REQ-012 Address SHALL equal the PC register at all times.
REQ-013 Instruction class SHALL be: Instruction[7:6]==2'b10 means two-byte (opcode + immediate); 8'hFF means HALT; all other values are one-byte.
REQ-014 The FSM SHALL have states FETCH_OP, FETCH_IMM and HALT.
REQ-015 A slot SHALL be free when Valid==0 or (Valid && Ready); a fetch occurs only in a free slot.
REQ-016 FETCH_OP with a free slot and a one-byte opcode: Opcode<=Instruction, Operand<=8'h00, Fetch_PC<=PC, Valid<=1, PC<=PC+1.
REQ-017 FETCH_OP with a free slot and a two-byte opcode: latch the opcode and its PC internally, Valid<=0, PC<=PC+1, go to FETCH_IMM.
REQ-018 FETCH_IMM: Operand<=Instruction, Opcode/Fetch_PC <= latched values, Valid<=1, PC<=PC+1, go to FETCH_OP.
REQ-019 FETCH_OP with opcode 8'hFF and a free slot: present it (Operand 8'h00, Valid<=1), PC unchanged, go to HALT, Halted<=1.
REQ-020 HALT: no fetches; Valid clears when the HALT instruction is accepted; PC frozen.
REQ-021 Stall (Valid && !Ready): Opcode, Operand, Fetch_PC, Valid and PC SHALL hold; the FSM SHALL NOT advance out of FETCH_OP.
REQ-022 Redirect SHALL take priority over all other events in any state: PC<=Redirect_Target, Valid<=0, pending opcode discarded, state<=FETCH_OP, Halted<=0.
REQ-023 Redirect concurrent with Valid && Ready: the output is consumed and no new instruction is fetched that cycle.
REQ-024 PC arithmetic SHALL be 8-bit modulo; 8'hFF+1 = 8'h00, and a two-byte opcode at 8'hFF takes its operand from 8'h00.
REQ-025 Peak throughput SHALL be one one-byte instruction per cycle; a two-byte instruction needs two cycles.

Reset
REQ-026 Rst_N low SHALL immediately force: PC=RESET_PC, state=FETCH_OP, Valid=0, Opcode=8'h00, Operand=8'h00, Fetch_PC=RESET_PC, Halted=0.
REQ-027 Reset asserted mid two-byte fetch SHALL discard the pending opcode.
REQ-028 The first Valid SHALL appear one edge after Rst_N deasserts, provided the opcode is one-byte.

Structure
REQ-029 A shared package cpu_pkg SHALL hold the FSM state enum, HALT_OPCODE=8'hFF and TWO_BYTE_PREFIX=2'b10.
REQ-030 A single sub-module, pc_register (8-bit register with load/increment/hold), is permitted; everything else SHALL be flat.

Verification
REQ-031 Reset; memory 0:8'h01, 1:8'h02; Ready=1 -> Valid at cycle 1: Opcode 01, Fetch_PC 00; cycle 2: Opcode 02, Fetch_PC 01.
REQ-032 Memory 0:8'h85, 1:8'h3C -> one Valid beat with Opcode 85, Operand 3C, Fetch_PC 00; next Address 02.
REQ-033 Ready=0 for 3 cycles while Valid -> outputs and Address constant; the next instruction appears one cycle after Ready=1.
REQ-034 Redirect=1, target 8'h40, during FETCH_IMM -> Valid=0 next cycle, Address 40, opcode 85 never presented.
REQ-035 Memory 5:8'hFF -> Valid with Opcode FF, Halted=1, Address stays 05; Redirect to 8'h10 clears Halted.
REQ-036 Redirect to 8'hFF, memory FF:8'h90, 00:8'h11 -> Opcode 90, Operand 11, Fetch_PC FF, next Address 01.
